serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Serial-to-parallel frame receiver. It is the receiving end of the serial-out path of the universal shift register.
- Detects a start bit, shifts in WIDTH data bits (qualified by a bit strobe), and checks the stop bit.
- Presents each good word on a parallel port through a single-entry valid/ready output buffer.
- Reports framing errors and overruns. Sits between a serial link and a parallel consumer.

Parameters:
- WIDTH, 8: data bits per frame; WIDTH >= 2.
- MSB_FIRST, 0: 0 = first data bit received lands in pout[0]; 1 = first data bit received lands in pout[WIDTH-1].
- PARITY_ODD, 0: parity sense, used only when PARITY_CHECK_EN is defined. 0 = even, 1 = odd.

Ports:
- clk  in  1  clock; all logic on posedge clk
- rst  in  1  synchronous, active-high reset
- sin_en  in  1  bit strobe; sin is sampled only on cycles with sin_en=1
- sin  in  1  serial data line; idles at 1
- pout  out  WIDTH  received word
- pout_valid  out  1  pout holds an unconsumed word
- pout_ready  in  1  consumer accepts pout this cycle
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0
- overrun  out  1  one-cycle pulse: completed word dropped because the buffer was full
- parity_err  out  1  one-cycle pulse: parity mismatch; tied 0 without PARITY_CHECK_EN
- busy  out  1  FSM not in IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; the polarity and synchronicity are fixed.
- Reset values: state=IDLE, bit_cnt=0, shift register=0, pout=0, pout_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
- rst overrides all other inputs. Reset mid-frame abandons the partial word with no error pulse.
- sin_en=0 cycles change nothing in the FSM; sin is ignored on those cycles.
- FSM states: IDLE, DATA, PARITY (present only with the macro), STOP.
- IDLE: sin_en & sin=0 -> DATA, bit_cnt=0. sin_en & sin=1 -> stay in IDLE.
- DATA: on each sin_en, shift sin in and increment bit_cnt.
  - MSB_FIRST=0: shift right, new bit enters at WIDTH-1, so after WIDTH bits the first-received bit is in [0].
  - MSB_FIRST=1: shift left, new bit enters at [0].
  - On the sin_en where bit_cnt==WIDTH-1: go to PARITY (macro on) or STOP. bit_cnt is $clog2(WIDTH) bits wide and returns to 0.
- STOP, on sin_en:
  - sin=1 and no parity error: word is complete. sin=0: frame_err pulses, the word is discarded, overrun does not pulse.
  - Always returns to IDLE. A 0 sampled at the stop position is never treated as a start bit.
- Output buffer, evaluated on the cycle a word completes:
  - If !pout_valid or pout_ready: pout <= word, pout_valid <= 1.
  - Else: overrun pulses, the new word is dropped, pout is unchanged.
  - Completion and consume in the same cycle load the new word with pout_valid held at 1 and no overrun.
- pout_valid & pout_ready with no completing word: pout_valid <= 0, and pout keeps its value.
- Latency: pout_valid rises on the clk edge after the edge that samples the stop bit (registered).
- Error pulses last exactly one cycle. They are registered, aligned with the point where pout_valid would have risen.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - PARITY state is inserted after DATA. The parity bit is sampled on its sin_en.
  - The expected parity is XOR of the data bits, XOR PARITY_ODD.
  - A mismatch is recorded. At STOP it pulses parity_err (and frame_err as well if the stop bit is 0), and the word is discarded.
- Not defined: there is no PARITY state, parity_err is tied 0, and the frame length is 1 + WIDTH + 1 bits.

Decomposition:
- Package usr_pkg holds:
  - rx_state_t enum: IDLE, DATA, PARITY, STOP.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- Sub-module rx_hold_buf (WIDTH): the single-entry valid/ready holding register with overrun detect. The top-level keeps the FSM and shifter.

Test Plan:
- Basic frame: WIDTH=8, MSB_FIRST=0, sin_en=1 every cycle, pout_ready=1. Send 0, then 1,0,1,0,0,1,0,1, then 1 -> pout=8'hA5, pout_valid high for 1 cycle, the cycle after the stop sample; no error pulses.
- Framing error: same frame with stop=0 -> frame_err pulses 1 cycle, pout_valid stays 0, busy=0 next cycle. A following clean 8'h3C frame is received correctly.
- Overrun: pout_ready=0, send 8'h3C then 8'hC3 -> pout=8'h3C valid, overrun pulses once at the second stop, pout stays 8'h3C. Raise pout_ready -> pout_valid drops.
- Strobe gating: sin_en=1 every 4th cycle, sin toggling randomly on sin_en=0 cycles, send 8'h96 -> pout=8'h96. MSB_FIRST=1 with the same bit sequence -> pout=8'h69.
- Reset mid-frame: rst for 1 cycle after 4 data bits -> busy=0, no pulses. Then send 8'h5A -> pout=8'h5A.
- Parity (PARITY_CHECK_EN, PARITY_ODD=0): 8'h07 with parity bit 1 -> accepted. With parity bit 0 -> parity_err pulse, no pout_valid.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_rx_hold_buf.sv
// Single-entry valid/ready holding register for received words, flagging overrun
// when a new word arrives while the previous one is still unconsumed.
module rx_hold_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (in_valid) begin
      if (!valid_q || out_ready) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH strobed data bits, stop bit, into a
// valid/ready hold buffer. Define PARITY_CHECK_EN to insert and check a parity bit.
module serial_frame_rx
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_en,
  input  logic             sin,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err,
  output logic             busy
);

  localparam int unsigned        CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_err_q, par_err_d;
  logic             done_q, done_d;
  logic             ferr_pend_q, ferr_pend_d;
  logic             frame_err_q, frame_err_d;
`ifdef PARITY_CHECK_EN
  logic             perr_pend_q, perr_pend_d;
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    done_d      = 1'b0;
    ferr_pend_d = 1'b0;
    frame_err_d = ferr_pend_q;
`ifdef PARITY_CHECK_EN
    perr_pend_d  = 1'b0;
    parity_err_d = perr_pend_q;
`endif
    if (sin_en) begin
      unique case (state_q)
        IDLE: begin
          if (sin == START_BIT) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
          end
        end
        DATA: begin
          if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], sin};
          else           shift_d = {sin, shift_q[WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_err_d = ((^shift_q) ^ PARITY_ODD) != sin;
          state_d   = STOP;
        end
        STOP: begin
          done_d      = (sin == STOP_BIT) && !par_err_q;
          ferr_pend_d = (sin != STOP_BIT);
`ifdef PARITY_CHECK_EN
          perr_pend_d = par_err_q;
`endif
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      done_q      <= 1'b0;
      ferr_pend_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_pend_q  <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      done_q      <= done_d;
      ferr_pend_q <= ferr_pend_d;
      frame_err_q <= frame_err_d;
`ifdef PARITY_CHECK_EN
      perr_pend_q  <= perr_pend_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // shift_q is still intact one cycle after the stop sample: the earliest
  // next start bit only reaches DATA on that edge, so it feeds the buffer directly.
  rx_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (done_q),
    .in_data  (shift_q),
    .out_ready(pout_ready),
    .out_data (pout),
    .out_valid(pout_valid),
    .overrun  (overrun)
  );

  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
